// File: rtl/msrv32_decode_stage.sv
// RV32I(+M) decode stage: decodes on accept, queues control bundles in a small FIFO,
// and holds a FENCE at the head until the downstream memory pipe is idle.
module msrv32_decode_stage #(
  parameter int DEPTH   = 2,
  parameter bit EN_MEXT = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        flush_in,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic        valid_out,
  input  logic        ready_in,
  input  logic        pipe_idle_in,
  input  logic        trap_taken_in,
  input  logic [1:0]  iadder_out_1_to_0_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [2:0]  wb_mux_sel_out,
  output logic [2:0]  imm_type_out,
  output logic [2:0]  csr_op_out,
  output logic [3:0]  alu_opcode_out,
  output logic [1:0]  load_size_out,
  output logic [2:0]  muldiv_op_out,
  output logic        alu_src_out,
  output logic        iadder_src_out,
  output logic        load_unsigned_out,
  output logic        rf_wr_en_out,
  output logic        csr_wr_en_out,
  output logic        muldiv_en_out,
  output logic        illegal_instr_out,
  output logic        misaligned_load_out,
  output logic        misaligned_store_out,
  output logic        mem_wr_req_out
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  wb_mux_sel, imm_type, csr_op;
    logic [3:0]  alu_opcode;
    logic [1:0]  load_size;
    logic [2:0]  muldiv_op;
    logic        alu_src, iadder_src, load_unsigned, rf_wr_en, csr_wr_en, muldiv_en;
    logic        illegal, is_load, is_store, is_fence;
  } bundle_t;

  typedef enum logic [1:0] {RUN, FENCE_WAIT, FENCE_GO} state_t;

  logic [4:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic is_op, is_op_imm, is_load, is_store, is_branch, is_jal, is_jalr;
  logic is_lui, is_auipc, is_misc, is_system, is_csr, known, bad_funct, illegal;
  bundle_t dec, head;

  assign opc       = instr_in[6:2];
  assign f3        = instr_in[14:12];
  assign f7        = instr_in[31:25];
  assign is_op     = opc == 5'b01100;
  assign is_op_imm = opc == 5'b00100;
  assign is_load   = opc == 5'b00000;
  assign is_store  = opc == 5'b01000;
  assign is_branch = opc == 5'b11000;
  assign is_jal    = opc == 5'b11011;
  assign is_jalr   = opc == 5'b11001;
  assign is_lui    = opc == 5'b01101;
  assign is_auipc  = opc == 5'b00101;
  assign is_misc   = opc == 5'b00011;
  assign is_system = opc == 5'b11100;
  assign is_csr    = is_system & (f3 != 3'b000);
  assign known     = |{is_op, is_op_imm, is_load, is_store, is_branch, is_jal, is_jalr,
                       is_lui, is_auipc, is_misc, is_system};

  // Reserved funct3/funct7 combinations within otherwise known opcodes.
  always_comb begin
    bad_funct = 1'b0;
    if (is_op)
      bad_funct = !((f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)) ||
                    (EN_MEXT && f7 == 7'h01));
    if (is_op_imm && f3 == 3'b001) bad_funct = f7 != 7'h00;
    if (is_op_imm && f3 == 3'b101) bad_funct = (f7 != 7'h00) && (f7 != 7'h20);
    if (is_branch) bad_funct = f3[2:1] == 2'b01;
    if (is_load)   bad_funct = (f3 == 3'b011) || (f3[2:1] == 2'b11);
    if (is_store)  bad_funct = f3 > 3'b010;
    if (is_jalr)   bad_funct = f3 != 3'b000;
  end

  assign illegal = (instr_in[1:0] != 2'b11) | ~known | bad_funct;

  always_comb begin
    dec               = '0;
    dec.instr         = instr_in;
    dec.pc            = pc_in;
    dec.wb_mux_sel    = {is_csr | is_jal | is_jalr, is_lui | is_auipc,
                         is_load | is_auipc | is_jal | is_jalr};
    dec.imm_type      = {is_lui | is_auipc | is_jal | is_csr, is_store | is_branch | is_csr,
                         is_op_imm | is_load | is_jalr | is_branch | is_jal};
    dec.alu_opcode    = {f7[5] & ~(is_op_imm & (f3 != 3'b101)), f3};
    dec.alu_src       = instr_in[5];
    dec.iadder_src    = is_load | is_store | is_jalr;
    dec.load_size     = f3[1:0];
    dec.load_unsigned = f3[2];
    dec.csr_op        = f3;
    dec.muldiv_op     = f3;
    dec.rf_wr_en      = ~illegal & (is_lui | is_auipc | is_jal | is_jalr | is_op | is_op_imm |
                                    is_load | is_csr);
    dec.csr_wr_en     = ~illegal & is_csr;
    dec.muldiv_en     = ~illegal & is_op & (f7 == 7'h01);
    dec.illegal       = illegal;
    dec.is_load       = is_load;
    dec.is_store      = is_store;
    dec.is_fence      = is_misc;
  end

  bundle_t        mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  logic           head_vld, push, pop;
  state_t         state, state_nxt;

  assign head_vld  = count != '0;
  assign ready_out = count < FULL;
  assign push      = valid_in & ready_out & ~flush_in;
  assign pop       = valid_out & ready_in & ~flush_in;
  assign head      = head_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clk_in)
    if (push) mem[wr_ptr] <= dec;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= RUN;
    end else if (flush_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= RUN;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      state <= state_nxt;
    end
  end

  // A FENCE at the head is withheld until downstream memory traffic has drained.
  always_comb begin
    state_nxt = state;
    valid_out = 1'b0;
    case (state)
      RUN:
        if (head_vld && head.is_fence) state_nxt = FENCE_WAIT;
        else valid_out = head_vld;
      FENCE_WAIT:
        if (pipe_idle_in) state_nxt = FENCE_GO;
      FENCE_GO: begin
        valid_out = head_vld;
        if (pop) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  logic [2:0] hf3;
  logic       mis;
  assign hf3 = head.instr[14:12];
  assign mis = hf3[1] ? (|iadder_out_1_to_0_in) : (hf3[0] & iadder_out_1_to_0_in[0]);

  assign instr_out            = head.instr;
  assign pc_out               = head.pc;
  assign wb_mux_sel_out       = head.wb_mux_sel;
  assign imm_type_out         = head.imm_type;
  assign csr_op_out           = head.csr_op;
  assign alu_opcode_out       = head.alu_opcode;
  assign load_size_out        = head.load_size;
  assign muldiv_op_out        = head.muldiv_op;
  assign alu_src_out          = head.alu_src;
  assign iadder_src_out       = head.iadder_src;
  assign load_unsigned_out    = head.load_unsigned;
  assign rf_wr_en_out         = head.rf_wr_en;
  assign csr_wr_en_out        = head.csr_wr_en;
  assign muldiv_en_out        = head.muldiv_en;
  assign illegal_instr_out    = head.illegal;
  assign misaligned_load_out  = valid_out & head.is_load & mis;
  assign misaligned_store_out = valid_out & head.is_store & mis;
  assign mem_wr_req_out       = valid_out & head.is_store & ~mis & ~trap_taken_in & ~head.illegal;
endmodule
